// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;

   typedef enum logic [2:0] {LEN, DATA, CHK, DONE, ERR} state_e;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into a word; pulses word_vld_o on the 4th byte.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              byte_vld_i,
   input  logic [7:0]        byte_i,
   output logic              word_vld_o,
   output logic [WORD_W-1:0] word_o
);
   logic [1:0]        cnt_q;
   logic [WORD_W-9:0] sh_q;

   // The completed word is presented combinationally alongside the final byte.
   assign word_vld_o = byte_vld_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word_o     = {byte_i, sh_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (byte_vld_i) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= word_o[WORD_W-1:8];
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer; holds the core until the program is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              out_ready,
   output logic              out_mem_we,
   output logic [31:0]       out_mem_addr,
   output logic [31:0]       out_mem_data,
   output logic              out_core_hold,
   output logic              out_done,
   output logic              out_error,
   output logic [ADDR_W:0]   out_words_loaded
);
   state_e            state_q, state_d;
   logic              ready_q, we_q, we_d, done_q, err_q;
   logic [31:0]       addr_q, addr_d, data_q, data_d;
   logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d;
   logic              hs, word_vld;
   logic [WORD_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] csum_q, csum_d;
`endif

   assign hs = in_valid && ready_q;

   word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (state_d != state_q),
      .byte_vld_i (hs),
      .byte_i     (in_byte),
      .word_vld_o (word_vld),
      .word_o     (word)
   );

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      idx_d   = idx_q;
      len_d   = len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         LEN: if (word_vld) begin
            if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end else if (word > 32'(DEPTH)) begin
               state_d = ERR;
            end else begin
               len_d   = word[ADDR_W:0];
               state_d = DATA;
            end
         end
         DATA: if (word_vld) begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR + (32'(idx_q) << 2);
            data_d = word;
            idx_d  = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ word;
            if (idx_d == len_q) state_d = CHK;
`else
            if (idx_d == len_q) state_d = DONE;
`endif
         end
         CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (word_vld) state_d = (word == csum_q) ? DONE : ERR;
`endif
         end
         default: ;
      endcase
   end

   // Done after a data write lags one cycle so the last write lands before the first fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LEN;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         done_q  <= (state_q == DONE) || ((state_q == CHK) && (state_d == DONE));
         err_q   <= (state_d == ERR);
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end
`endif

   assign out_ready        = ready_q;
   assign out_mem_we       = we_q;
   assign out_mem_addr     = addr_q;
   assign out_mem_data     = data_q;
   assign out_core_hold    = ~done_q;
   assign out_done         = done_q;
   assign out_error        = err_q;
   assign out_words_loaded = idx_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued, a monitor checks strobes.
module tb_imem_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;
   localparam logic [31:0] BASE = 32'h0;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        in_byte = 8'h00;
   logic              in_valid = 1'b0;
   logic              out_ready, out_mem_we, out_core_hold, out_done, out_error;
   logic [31:0]       out_mem_addr, out_mem_data;
   logic [ADDR_W:0]   out_words_loaded;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
      .out_ready(out_ready), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
      .out_mem_data(out_mem_data), .out_core_hold(out_core_hold), .out_done(out_done),
      .out_error(out_error), .out_words_loaded(out_words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0, fails = 0, cyc = 0, last_we_cyc = -1, done_rise = -1, stalls = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // Monitor: every strobe must match the head of the expected-write queue.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (out_mem_we) begin
            if (exp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", out_mem_addr, out_mem_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", 64'(out_mem_addr), 64'(mon_e.a));
               chk("wr_data", 64'(out_mem_data), 64'(mon_e.d));
            end
            last_we_cyc = cyc;
         end
         if (out_done && !done_prev) done_rise = cyc;
         if (out_done && out_error) begin
            checks++; fails++;
            $display("FAIL done_and_error: both 1, expected at most one");
         end
         done_prev = out_done;
      end else begin
         done_prev = 1'b0;
      end
   end

   // Tasks start and end at a negedge; in_valid is left high for back-to-back bytes.
   task automatic send(input logic [7:0] b);
      int tries = 0;
      in_byte  = b;
      in_valid = 1'b1;
      while (!out_ready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      if (tries > 0) stalls++;
      if (!out_ready) begin
         checks++; fails++;
         $display("FAIL send_timeout: out_ready 0 for 20 cycles, expected 1");
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!out_done && !out_error && n < 50) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (n == 50) begin
         checks++; fails++;
         $display("FAIL end_timeout: neither done nor error after 50 cycles, expected one");
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rst_ready", 64'(out_ready), 64'd0);
      chk("rst_hold",  64'(out_core_hold), 64'd1);
      chk("rst_words", 64'(out_words_loaded), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_we_cyc = -1;
      done_rise   = -1;
      @(negedge clk);
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      chk("rst_ready0", 64'(out_ready), 64'd0);
      chk("rst_we",     64'(out_mem_we), 64'd0);
      chk("rst_addr",   64'(out_mem_addr), 64'(BASE));
      chk("rst_data",   64'(out_mem_data), 64'd0);
      chk("rst_hold0",  64'(out_core_hold), 64'd1);
      chk("rst_done",   64'(out_done), 64'd0);
      chk("rst_err",    64'(out_error), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(out_ready), 64'd1);

      // N = 0
      send_word(32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h0);
`endif
      idle();
      wait_end();
      chk("t1_done",  64'(out_done), 64'd1);
      chk("t1_hold",  64'(out_core_hold), 64'd0);
      chk("t1_words", 64'(out_words_loaded), 64'd0);
      chk("t1_err",   64'(out_error), 64'd0);

      // N = 2, streamed back to back
      do_reset();
      stalls = 0;
      exp_q.push_back('{a: BASE,           d: 32'h12345678});
      exp_q.push_back('{a: BASE + 32'd4,   d: 32'hDEADBEEF});
      send_word(32'd2);
      send_word(32'h12345678);
      send_word(32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'hCC99E897);
`endif
      idle();
      wait_end();
      chk("t2_no_stall", 64'(stalls), 64'd0);
      chk("t2_done",     64'(out_done), 64'd1);
      chk("t2_words",    64'(out_words_loaded), 64'd2);
      chk("t2_q_empty",  64'(exp_q.size()), 64'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("t2_done_lag", 64'(done_rise), 64'(last_we_cyc + 1));
`endif

      // N = DEPTH+1 -> error
      do_reset();
      send_word(32'd257);
      in_valid = 1'b0;
      #1;
      chk("t3_err",   64'(out_error), 64'd1);
      chk("t3_ready", 64'(out_ready), 64'd0);
      chk("t3_hold",  64'(out_core_hold), 64'd1);
      chk("t3_done",  64'(out_done), 64'd0);
      repeat (3) @(negedge clk);
      chk("t3_words", 64'(out_words_loaded), 64'd0);

      // N = 1 with gapped valid, then bytes offered after DONE
      do_reset();
      exp_q.push_back('{a: BASE, d: 32'h00000001});
      for (int i = 0; i < 4; i++) begin send(i == 0 ? 8'h01 : 8'h00); idle(); end
      send(8'h01); idle();
      for (int i = 0; i < 3; i++) begin send(8'h00); idle(); end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h01); idle();
      for (int i = 0; i < 3; i++) begin send(8'h00); idle(); end
`endif
      wait_end();
      chk("t4_done", 64'(out_done), 64'd1);
      in_byte  = 8'hAA;
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_ready_low", 64'(out_ready), 64'd0);
      chk("t4_words",     64'(out_words_loaded), 64'd1);
      chk("t4_q_empty",   64'(exp_q.size()), 64'd0);
      in_valid = 1'b0;

      // Reset after two data bytes; resend a fresh N = 1 stream
      do_reset();
      send_word(32'd1);
      send(8'hAA);
      send(8'hBB);
      do_reset();
      exp_q.push_back('{a: BASE, d: 32'h11223344});
      send_word(32'd1);
      send_word(32'h11223344);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h11223344);
`endif
      idle();
      wait_end();
      chk("t5_done",    64'(out_done), 64'd1);
      chk("t5_words",   64'(out_words_loaded), 64'd1);
      chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      do_reset();
      exp_q.push_back('{a: BASE,         d: 32'h0000000F});
      exp_q.push_back('{a: BASE + 32'd4, d: 32'h000000F0});
      send_word(32'd2); send_word(32'h0F); send_word(32'hF0); send_word(32'hFF);
      idle();
      wait_end();
      chk("c1_done", 64'(out_done), 64'd1);
      chk("c1_err",  64'(out_error), 64'd0);
      do_reset();
      exp_q.push_back('{a: BASE,         d: 32'h0000000F});
      exp_q.push_back('{a: BASE + 32'd4, d: 32'h000000F0});
      send_word(32'd2); send_word(32'h0F); send_word(32'hF0); send_word(32'hFE);
      idle();
      wait_end();
      chk("c2_err",  64'(out_error), 64'd1);
      chk("c2_hold", 64'(out_core_hold), 64'd1);
      chk("c2_q_empty", 64'(exp_q.size()), 64'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
